// File: rtl/riscv_idu.sv
// RV32I instruction decode stage: combinational decode of the incoming IFU beat,
// registered output with a one-entry skid buffer so ifu_ready comes straight from a flop.
module riscv_idu #(
   parameter int XLEN        = 32,
   parameter bit RESET_VALID = 1'b0
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            ifu_valid,
   output logic            ifu_ready,
   input  logic [XLEN-1:0] ifu_pc,
   input  logic [31:0]     ifu_instr,
   input  logic            ifu_fault,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [3:0]      id_class,
   output logic [4:0]      id_rd,
   output logic [4:0]      id_rs1,
   output logic [4:0]      id_rs2,
   output logic [XLEN-1:0] id_imm,
   output logic [2:0]      id_funct3,
   output logic            id_alt,
   output logic            id_illegal,
   output logic            id_fault
);

   typedef enum logic [3:0] {
      CLS_LUI = 4'd0, CLS_AUIPC = 4'd1, CLS_JAL = 4'd2, CLS_JALR = 4'd3,
      CLS_BRANCH = 4'd4, CLS_LOAD = 4'd5, CLS_STORE = 4'd6, CLS_OPIMM = 4'd7,
      CLS_OP = 4'd8, CLS_FENCE = 4'd9, CLS_SYSTEM = 4'd10, CLS_ILLEGAL = 4'd15
   } op_class_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      op_class_e       cls;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] imm;
      logic [2:0]      funct3;
      logic            alt;
      logic            illegal;
      logic            fault;
   } dec_t;

   logic [6:0]      opcode;
   logic [6:0]      funct7;
   logic [2:0]      funct3;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode = ifu_instr[6:0];
   assign funct7 = ifu_instr[31:25];
   assign funct3 = ifu_instr[14:12];
   assign imm_i  = {{(XLEN-12){ifu_instr[31]}}, ifu_instr[31:20]};
   assign imm_s  = {{(XLEN-12){ifu_instr[31]}}, ifu_instr[31:25], ifu_instr[11:7]};
   assign imm_b  = {{(XLEN-13){ifu_instr[31]}}, ifu_instr[31], ifu_instr[7],
                    ifu_instr[30:25], ifu_instr[11:8], 1'b0};
   assign imm_u  = {{(XLEN-32){ifu_instr[31]}}, ifu_instr[31:12], 12'b0};
   assign imm_j  = {{(XLEN-21){ifu_instr[31]}}, ifu_instr[31], ifu_instr[19:12],
                    ifu_instr[20], ifu_instr[30:21], 1'b0};

   dec_t dec;
   logic ill;

   // NOTE: every field gets a default before the case so no path leaves a latch behind.
   always_comb begin
      dec        = '0;
      dec.pc     = ifu_pc;
      dec.funct3 = funct3;
      dec.cls    = CLS_ILLEGAL;
      ill        = 1'b0;
      unique case (opcode)
         7'b0110111: begin dec.cls = CLS_LUI;   dec.rd = ifu_instr[11:7]; dec.imm = imm_u; end
         7'b0010111: begin dec.cls = CLS_AUIPC; dec.rd = ifu_instr[11:7]; dec.imm = imm_u; end
         7'b1101111: begin dec.cls = CLS_JAL;   dec.rd = ifu_instr[11:7]; dec.imm = imm_j; end
         7'b1100111: begin
            dec.cls = CLS_JALR; dec.rd = ifu_instr[11:7]; dec.rs1 = ifu_instr[19:15];
            dec.imm = imm_i;    ill    = (funct3 != 3'd0);
         end
         7'b1100011: begin
            dec.cls = CLS_BRANCH; dec.rs1 = ifu_instr[19:15]; dec.rs2 = ifu_instr[24:20];
            dec.imm = imm_b;      ill     = (funct3 == 3'd2) || (funct3 == 3'd3);
         end
         7'b0000011: begin
            dec.cls = CLS_LOAD; dec.rd = ifu_instr[11:7]; dec.rs1 = ifu_instr[19:15];
            dec.imm = imm_i;    ill    = (funct3 == 3'd3) || (funct3 >= 3'd6);
         end
         7'b0100011: begin
            dec.cls = CLS_STORE; dec.rs1 = ifu_instr[19:15]; dec.rs2 = ifu_instr[24:20];
            dec.imm = imm_s;     ill     = (funct3 > 3'd2);
         end
         7'b0010011: begin
            dec.cls = CLS_OPIMM; dec.rd = ifu_instr[11:7]; dec.rs1 = ifu_instr[19:15];
            dec.imm = imm_i;
            if (funct3 == 3'd1) ill = (funct7 != 7'h00);
            if (funct3 == 3'd5) begin
               ill     = (funct7 != 7'h00) && (funct7 != 7'h20);
               dec.alt = ifu_instr[30];
            end
         end
         7'b0110011: begin
            dec.cls = CLS_OP; dec.rd = ifu_instr[11:7]; dec.rs1 = ifu_instr[19:15];
            dec.rs2 = ifu_instr[24:20]; dec.alt = ifu_instr[30];
            ill = !((funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
         end
         7'b0001111: begin dec.cls = CLS_FENCE; dec.imm = imm_i; end
         7'b1110011: begin
            dec.cls = CLS_SYSTEM; dec.imm = imm_i;
            ill = (ifu_instr != 32'h0000_0073) && (ifu_instr != 32'h0010_0073);
         end
         default: ill = 1'b1;
      endcase
      if (ill || ifu_fault) begin
         dec.cls     = CLS_ILLEGAL;
         dec.rd      = '0;
         dec.rs1     = '0;
         dec.rs2     = '0;
         dec.imm     = '0;
         dec.alt     = 1'b0;
         dec.illegal = ill && !ifu_fault;
         dec.fault   = ifu_fault;
         if (ifu_fault) dec.funct3 = '0;
      end
   end

   dec_t out_q, skid_q;
   logic out_valid, skid_valid, ready_q;
   logic accept, load_out, skid_nxt;

   assign accept   = ifu_valid && ready_q;
   assign load_out = !out_valid || id_ready;
   assign skid_nxt = !load_out && (skid_valid || accept);

   // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid  <= RESET_VALID;
         skid_valid <= 1'b0;
         ready_q    <= 1'b1;
         out_q      <= '0;
         skid_q     <= '0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         if (load_out) begin
            if (skid_valid) begin
               out_q     <= skid_q;
               out_valid <= 1'b1;
            end else if (accept) begin
               out_q     <= dec;
               out_valid <= 1'b1;
            end else begin
               out_valid <= 1'b0;
            end
         end else if (accept) begin
            skid_q <= dec;
         end
         skid_valid <= skid_nxt;
         ready_q    <= !skid_nxt;
      end
   end

   assign ifu_ready  = ready_q;
   assign id_valid   = out_valid;
   assign id_pc      = out_q.pc;
   assign id_class   = out_q.cls;
   assign id_rd      = out_q.rd;
   assign id_rs1     = out_q.rs1;
   assign id_rs2     = out_q.rs2;
   assign id_imm     = out_q.imm;
   assign id_funct3  = out_q.funct3;
   assign id_alt     = out_q.alt;
   assign id_illegal = out_q.illegal;
   assign id_fault   = out_q.fault;

endmodule

// File: tb/tb_riscv_idu.sv
// Directed bench for riscv_idu: decode vector table streamed back-to-back,
// then hand sequences for skid ordering, flush and asynchronous reset.
module tb_riscv_idu;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        ifu_valid = 1'b0;
   logic        ifu_ready;
   logic [31:0] ifu_pc = '0;
   logic [31:0] ifu_instr = '0;
   logic        ifu_fault = 1'b0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_pc;
   logic [3:0]  id_class;
   logic [4:0]  id_rd, id_rs1, id_rs2;
   logic [31:0] id_imm;
   logic [2:0]  id_funct3;
   logic        id_alt, id_illegal, id_fault;

   riscv_idu #(.XLEN(32), .RESET_VALID(1'b0)) dut (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .ifu_pc(ifu_pc),
      .ifu_instr(ifu_instr), .ifu_fault(ifu_fault),
      .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_class(id_class),
      .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_imm(id_imm),
      .id_funct3(id_funct3), .id_alt(id_alt), .id_illegal(id_illegal), .id_fault(id_fault)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic        fault;
      logic [3:0]  cls;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic [2:0]  f3;
      logic        alt, ill;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs [NV];

   task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
      ifu_valid = 1'b1;
      ifu_pc    = pc;
      ifu_instr = instr;
      ifu_fault = fault;
   endtask

   initial begin
      vecs[0]  = '{"addi",      32'h0050_0093, 0, 4'd7,  5'd1, 5'd0, 5'd0, 32'h0000_0005, 3'd0, 0, 0};
      vecs[1]  = '{"beq",       32'hFE00_0EE3, 0, 4'd4,  5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 3'd0, 0, 0};
      vecs[2]  = '{"sub",       32'h4020_81B3, 0, 4'd8,  5'd3, 5'd1, 5'd2, 32'h0000_0000, 3'd0, 1, 0};
      vecs[3]  = '{"zero_word", 32'h0000_0000, 0, 4'd15, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 3'd0, 0, 1};
      vecs[4]  = '{"mul",       32'h0220_81B3, 0, 4'd15, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 3'd0, 0, 1};
      vecs[5]  = '{"fault",     32'h0050_0093, 1, 4'd15, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 3'd0, 0, 0};
      vecs[6]  = '{"lui",       32'h1234_52B7, 0, 4'd0,  5'd5, 5'd0, 5'd0, 32'h1234_5000, 3'd5, 0, 0};
      vecs[7]  = '{"jal",       32'h0080_00EF, 0, 4'd2,  5'd1, 5'd0, 5'd0, 32'h0000_0008, 3'd0, 0, 0};
      vecs[8]  = '{"lw",        32'hFFC1_A103, 0, 4'd5,  5'd2, 5'd3, 5'd0, 32'hFFFF_FFFC, 3'd2, 0, 0};
      vecs[9]  = '{"sw",        32'h0051_2623, 0, 4'd6,  5'd0, 5'd2, 5'd5, 32'h0000_000C, 3'd2, 0, 0};
      vecs[10] = '{"srai",      32'h4032_5213, 0, 4'd7,  5'd4, 5'd4, 5'd0, 32'h0000_0403, 3'd5, 1, 0};
      vecs[11] = '{"jalr_f3",   32'h0000_1067, 0, 4'd15, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 3'd0, 0, 1};
      vecs[12] = '{"ecall",     32'h0000_0073, 0, 4'd10, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 3'd0, 0, 0};
      vecs[13] = '{"ebreak",    32'h0010_0073, 0, 4'd10, 5'd0, 5'd0, 5'd0, 32'h0000_0001, 3'd0, 0, 0};
      vecs[14] = '{"wfi",       32'h1050_0073, 0, 4'd15, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 3'd0, 0, 1};
      vecs[15] = '{"load_f3",   32'h0000_3003, 0, 4'd15, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 3'd0, 0, 1};
      vecs[16] = '{"branch_f3", 32'h0000_2063, 0, 4'd15, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 3'd0, 0, 1};
      vecs[17] = '{"auipc",     32'h8000_0097, 0, 4'd1,  5'd1, 5'd0, 5'd0, 32'h8000_0000, 3'd0, 0, 0};
      vecs[18] = '{"fence",     32'h0FF0_000F, 0, 4'd9,  5'd0, 5'd0, 5'd0, 32'h0000_00FF, 3'd0, 0, 0};
      vecs[19] = '{"slli_f7",   32'h4010_1093, 0, 4'd15, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 3'd0, 0, 1};

      // Reset state
      #12;
      check("reset_id_valid", id_valid, 1'b0);
      check("reset_ifu_ready", ifu_ready, 1'b1);
      check("reset_data", {id_pc, id_class, id_rd, id_rs1, id_rs2, id_imm, id_funct3,
                           id_alt, id_illegal, id_fault}, '0);
      @(negedge clock);
      reset_n = 1'b1;

      // Decode table streamed back-to-back with id_ready held high
      id_ready = 1'b1;
      for (int i = 0; i <= NV; i++) begin
         @(negedge clock);
         if (i > 0) begin
            vec_t v;
            logic [2:0] f3_got;
            v = vecs[i-1];
            f3_got = (v.cls == 4'd15) ? 3'd0 : id_funct3;
            check(v.name,
                  {id_valid, ifu_ready, id_pc, id_class, id_rd, id_rs1, id_rs2, id_imm,
                   f3_got, id_alt, id_illegal, id_fault},
                  {1'b1, 1'b1, 32'h1000 + 32'(4*(i-1)), v.cls, v.rd, v.rs1, v.rs2, v.imm,
                   v.f3, v.alt, v.ill, v.fault});
         end
         if (i < NV) drive(32'h1000 + 32'(4*i), vecs[i].instr, vecs[i].fault);
         else ifu_valid = 1'b0;
      end
      ifu_fault = 1'b0;
      @(negedge clock);
      check("drain_idle", id_valid, 1'b0);

      // Skid: second beat parks while stalled, order preserved on release
      id_ready = 1'b0;
      drive(32'h0, 32'h0050_0093, 1'b0);
      @(negedge clock);
      check("skid_first_out", {id_valid, ifu_ready, id_pc}, {1'b1, 1'b1, 32'h0});
      drive(32'h4, 32'h4020_81B3, 1'b0);
      @(negedge clock);
      check("skid_full_ready", {ifu_ready, id_valid, id_pc, id_class}, {1'b0, 1'b1, 32'h0, 4'd7});
      ifu_valid = 1'b0;
      @(negedge clock);
      check("skid_stall_stable", {id_valid, id_pc, id_class, id_imm, id_rd},
            {1'b1, 32'h0, 4'd7, 32'h5, 5'd1});
      id_ready = 1'b1;
      @(negedge clock);
      check("skid_second_out", {id_valid, ifu_ready, id_pc, id_class, id_alt},
            {1'b1, 1'b1, 32'h4, 4'd8, 1'b1});
      @(negedge clock);
      check("skid_drained", id_valid, 1'b0);

      // Flush with output and skid full and a beat on the input
      id_ready = 1'b0;
      drive(32'h200, 32'h0050_0093, 1'b0);
      @(negedge clock);
      drive(32'h204, 32'h0050_0093, 1'b0);
      @(negedge clock);
      check("flush_pre_full", {id_valid, ifu_ready}, {1'b1, 1'b0});
      drive(32'h208, 32'h0050_0093, 1'b0);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      ifu_valid = 1'b0;
      check("flush_empty", {id_valid, ifu_ready}, {1'b0, 1'b1});
      id_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         check("flush_no_stale", id_valid, 1'b0);
      end

      // Flush while ready: the same-cycle accepted beat is dropped
      drive(32'h300, 32'h0050_0093, 1'b0);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      ifu_valid = 1'b0;
      check("flush_drop_input", {id_valid, ifu_ready}, {1'b0, 1'b1});
      @(negedge clock);
      check("flush_drop_after", id_valid, 1'b0);

      // Asynchronous reset mid-stream with both registers full
      id_ready = 1'b0;
      drive(32'h400, 32'h0050_0093, 1'b0);
      @(negedge clock);
      drive(32'h404, 32'h0050_0093, 1'b0);
      @(negedge clock);
      ifu_valid = 1'b0;
      check("rst_pre_full", {id_valid, ifu_ready}, {1'b1, 1'b0});
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_async_clear", {id_valid, ifu_ready, id_pc}, {1'b0, 1'b1, 32'h0});
      @(negedge clock);
      reset_n = 1'b1;
      id_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         check("rst_no_stale", {id_valid, ifu_ready}, {1'b0, 1'b1});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
